// File: rtl/fifo_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fifo_pkg
// Description : Gray/binary conversion helpers and read-mode constants shared
//               by the async-FIFO read-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FWFT_STD  = 0;
    localparam int FWFT_FALL = 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rptr_empty_prog_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rptr_empty_prog_if
// Description : Read-side bundle between the reader, the FIFO memory and the
//               read-pointer/empty-flag block.
// Revision    : 1.0 - initial release
// ============================================================================
interface rptr_empty_prog_if #(
    parameter int ASIZE = 5,
    parameter int DSIZE = 8
);
    logic             rinc;
    logic [ASIZE:0]   rq2_wptr;
    logic [DSIZE-1:0] rmem_data;
    logic [ASIZE:0]   ae_thresh;
    logic             runderflow_clr;
    logic [ASIZE-1:0] raddr;
    logic [ASIZE:0]   rptr;
    logic [DSIZE-1:0] rdata;
    logic             rvalid;
    logic             rempty;
    logic             ralmostempty;
    logic [ASIZE:0]   rlevel;
    logic             runderflow;

    modport master (
        output rinc, rq2_wptr, rmem_data, ae_thresh, runderflow_clr,
        input  raddr, rptr, rdata, rvalid, rempty, ralmostempty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr, rmem_data, ae_thresh, runderflow_clr,
        output raddr, rptr, rdata, rvalid, rempty, ralmostempty, rlevel, runderflow
    );
endinterface
`default_nettype wire

// File: rtl/rptr_empty_prog_gray2bin.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gray2bin
// Description : Combinational Gray-to-binary converter for the synchronised
//               write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin_o[gi] = ^gray_i[WIDTH-1:gi];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/rptr_empty_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rptr_empty_prog
// Description : FIFO read-side pointer, empty/almost-empty flags, occupancy and
//               sticky underflow, with standard or first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_prog
    import fifo_pkg::*;
#(
    parameter int ASIZE = 5,
    parameter int DSIZE = 8,
    parameter int FWFT  = 0
) (
    input  logic              rclk,
    input  logic              rrst_n,
    rptr_empty_prog_if.slave  bus
);
    localparam int PW = ASIZE + 1;
    localparam logic [ASIZE+1:0] c_depth = {1'b0, 1'b1, {ASIZE{1'b0}}};

    logic [ASIZE:0]   rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d, rempty_q, rempty_d;
    logic             rae_q, rae_d, runf_q, runf_d;
    logic [ASIZE:0]   wbin, mem_level, next_mem_level;
    logic [ASIZE+1:0] level_sum;
    logic             pop, fetch, underflow, head_cnt;

    gray2bin #(.WIDTH(PW)) u_gray2bin (
        .gray_i (bus.rq2_wptr),
        .bin_o  (wbin)
    );

    always_comb begin
        mem_level = wbin - rbin_q;
        underflow = bus.rinc & rempty_q;
        pop       = 1'b0;
        fetch     = 1'b0;
        rvalid_d  = 1'b0;
        rbin_d    = rbin_q;
        rdata_d   = rdata_q;
        if (FWFT == FWFT_FALL) begin
            // The head register refills in the same cycle it is popped.
            pop      = bus.rinc & rvalid_q;
            fetch    = (mem_level != '0) & (~rvalid_q | pop);
            rvalid_d = fetch | (rvalid_q & ~pop);
        end else begin
            pop      = bus.rinc & ~rempty_q;
            fetch    = pop;
            rvalid_d = pop;
        end
        if (fetch) begin
            rbin_d  = rbin_q + {{ASIZE{1'b0}}, 1'b1};
            rdata_d = bus.rmem_data;
        end
        next_mem_level = wbin - rbin_d;
        head_cnt       = (FWFT == FWFT_FALL) ? rvalid_d : 1'b0;
        level_sum      = {1'b0, next_mem_level} + {{(ASIZE+1){1'b0}}, head_cnt};
        // A skewed pointer can momentarily imply more than a full FIFO.
        rlevel_d = (level_sum > c_depth) ? c_depth[ASIZE:0] : level_sum[ASIZE:0];
        rempty_d = (FWFT == FWFT_FALL) ? ~rvalid_d : (next_mem_level == '0);
        rae_d    = (rlevel_d <= bus.ae_thresh);
        runf_d   = underflow | (runf_q & ~bus.runderflow_clr);
        rptr_d   = PW'(bin2gray(32'(rbin_d)));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rdata_q  <= '0;
            rlevel_q <= '0;
            rvalid_q <= 1'b0;
            rempty_q <= 1'b1;
            rae_q    <= 1'b1;
            runf_q   <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rdata_q  <= rdata_d;
            rlevel_q <= rlevel_d;
            rvalid_q <= rvalid_d;
            rempty_q <= rempty_d;
            rae_q    <= rae_d;
            runf_q   <= runf_d;
        end
    end

    assign bus.raddr        = rbin_q[ASIZE-1:0];
    assign bus.rptr         = rptr_q;
    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.rempty       = rempty_q;
    assign bus.ralmostempty = rae_q;
    assign bus.rlevel       = rlevel_q;
    assign bus.runderflow   = runf_q;

endmodule
`default_nettype wire

// File: tb/tb_rptr_empty_prog.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rptr_empty_prog
// Description : Drives a standard-mode and a FWFT-mode instance side by side
//               and compares both against an occupancy-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rptr_empty_prog;
    import fifo_pkg::*;

    localparam int ASIZE = 5;
    localparam int DSIZE = 8;
    localparam int DEPTH = 32;
    localparam int MODP  = 64;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       rinc = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] thresh = 6'd1;
    int         wr = 0;
    logic [7:0] mem [DEPTH];

    int checks = 0;
    int errors = 0;

    // reference state: s = standard instance, f = fall-through instance
    int         m0_rd, m0_level, m1_rd, m1_level;
    bit         m0_empty, m0_valid, m0_ae, m0_unf;
    bit         m1_valid, m1_ae, m1_unf;
    logic [7:0] m0_data, m1_data;

    always #5 rclk = ~rclk;

    rptr_empty_prog_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) if0 ();
    rptr_empty_prog_if #(.ASIZE(ASIZE), .DSIZE(DSIZE)) if1 ();

    rptr_empty_prog #(.ASIZE(ASIZE), .DSIZE(DSIZE), .FWFT(0)) dut0 (
        .rclk (rclk), .rrst_n (rrst_n), .bus (if0.slave));
    rptr_empty_prog #(.ASIZE(ASIZE), .DSIZE(DSIZE), .FWFT(1)) dut1 (
        .rclk (rclk), .rrst_n (rrst_n), .bus (if1.slave));

    assign if0.rinc           = rinc;
    assign if1.rinc           = rinc;
    assign if0.runderflow_clr = clr;
    assign if1.runderflow_clr = clr;
    assign if0.ae_thresh      = thresh;
    assign if1.ae_thresh      = thresh;
    assign if0.rq2_wptr       = 6'(bin2gray(32'(wr)));
    assign if1.rq2_wptr       = 6'(bin2gray(32'(wr)));
    assign if0.rmem_data      = mem[if0.raddr];
    assign if1.rmem_data      = mem[if1.raddr];

    function automatic int occ(int w, int r);
        return (w - r + MODP) % MODP;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m0_rd = 0; m0_level = 0; m0_empty = 1; m0_valid = 0; m0_ae = 1; m0_unf = 0; m0_data = '0;
        m1_rd = 0; m1_level = 0; m1_valid = 0; m1_ae = 1; m1_unf = 0; m1_data = '0;
    endtask

    task automatic model_step();
        bit pop, fetch;
        int o;
        pop    = rinc && !m0_empty;
        m0_unf = (rinc && m0_empty) || (m0_unf && !clr);
        if (pop) begin
            m0_data = mem[m0_rd % DEPTH];
            m0_rd   = (m0_rd + 1) % MODP;
        end
        m0_valid = pop;
        o        = occ(wr, m0_rd);
        m0_empty = (o == 0);
        m0_level = (o > DEPTH) ? DEPTH : o;
        m0_ae    = (m0_level <= int'(thresh));

        pop    = rinc && m1_valid;
        m1_unf = (rinc && !m1_valid) || (m1_unf && !clr);
        fetch  = (occ(wr, m1_rd) > 0) && (!m1_valid || pop);
        if (fetch) begin
            m1_data = mem[m1_rd % DEPTH];
            m1_rd   = (m1_rd + 1) % MODP;
        end
        m1_valid = fetch || (m1_valid && !pop);
        o        = occ(wr, m1_rd) + (m1_valid ? 1 : 0);
        m1_level = (o > DEPTH) ? DEPTH : o;
        m1_ae    = (m1_level <= int'(thresh));
    endtask

    task automatic check_all();
        chk("s_rptr",         32'(if0.rptr),         bin2gray(32'(m0_rd)));
        chk("s_raddr",        32'(if0.raddr),        32'(m0_rd % DEPTH));
        chk("s_rdata",        32'(if0.rdata),        32'(m0_data));
        chk("s_rvalid",       32'(if0.rvalid),       32'(m0_valid));
        chk("s_rempty",       32'(if0.rempty),       32'(m0_empty));
        chk("s_ralmostempty", 32'(if0.ralmostempty), 32'(m0_ae));
        chk("s_rlevel",       32'(if0.rlevel),       32'(m0_level));
        chk("s_runderflow",   32'(if0.runderflow),   32'(m0_unf));
        chk("f_rptr",         32'(if1.rptr),         bin2gray(32'(m1_rd)));
        chk("f_raddr",        32'(if1.raddr),        32'(m1_rd % DEPTH));
        chk("f_rdata",        32'(if1.rdata),        32'(m1_data));
        chk("f_rvalid",       32'(if1.rvalid),       32'(m1_valid));
        chk("f_rempty",       32'(if1.rempty),       32'(!m1_valid));
        chk("f_ralmostempty", 32'(if1.ralmostempty), 32'(m1_ae));
        chk("f_rlevel",       32'(if1.rlevel),       32'(m1_level));
        chk("f_runderflow",   32'(if1.runderflow),   32'(m1_unf));
    endtask

    task automatic tick();
        @(posedge rclk);
        model_step();
        #1;
        check_all();
    endtask

    function automatic bit room();
        return (occ(wr, m0_rd) < DEPTH) && (occ(wr, m1_rd) + (m1_valid ? 1 : 0) < DEPTH);
    endfunction

    task automatic push_word(logic [7:0] v);
        mem[wr % DEPTH] = v;
        wr = (wr + 1) % MODP;
    endtask

    // Called just after a tick: reset lands between clock edges.
    task automatic async_reset();
        #2;
        rrst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_mid_s_rempty", 32'(if0.rempty), 32'd1);
        chk("rst_mid_f_rvalid", 32'(if1.rvalid), 32'd0);
        chk("rst_mid_s_rptr",   32'(if0.rptr),   32'd0);
        rinc = 1'b0;
        clr  = 1'b0;
        wr   = 0;
        @(posedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        repeat (2) @(negedge rclk);
        check_all();
        chk("rst_s_ralmostempty", 32'(if0.ralmostempty), 32'd1);
        chk("rst_f_rlevel",       32'(if1.rlevel),       32'd0);
        rrst_n = 1'b1;

        // three words, standard read
        tick();
        push_word(8'hA1); push_word(8'hB2); push_word(8'hC3);
        tick();
        chk("t33_rempty", 32'(if0.rempty), 32'd0);
        chk("t33_rlevel", 32'(if0.rlevel), 32'd3);
        chk("t33_ae",     32'(if0.ralmostempty), 32'd0);
        rinc = 1'b1;
        tick(); chk("t33_word0", 32'(if0.rdata), 32'hA1);
        tick(); chk("t33_word1", 32'(if0.rdata), 32'hB2);
        tick(); chk("t33_word2", 32'(if0.rdata), 32'hC3);
        chk("t33_empty_after", 32'(if0.rempty), 32'd1);
        chk("t33_level_after", 32'(if0.rlevel), 32'd0);
        rinc = 1'b0;
        tick();

        // mid-burst asynchronous reset
        for (int k = 0; k < 5; k++) push_word(8'(8'h10 + k));
        tick();
        rinc = 1'b1;
        tick(); tick();
        async_reset();

        // FWFT single word
        tick();
        push_word(8'h5A);
        tick();
        chk("t34_rvalid", 32'(if1.rvalid), 32'd1);
        chk("t34_rdata",  32'(if1.rdata),  32'h5A);
        rinc = 1'b1;
        tick();
        chk("t34_rvalid_after", 32'(if1.rvalid), 32'd0);
        chk("t34_rptr",         32'(if1.rptr),   32'd1);

        // underflow set / simultaneous clear / clear
        tick();
        chk("t37_unf",  32'(if0.runderflow), 32'd1);
        chk("t37_rptr", 32'(if0.rptr),       32'd1);
        clr = 1'b1;
        tick();
        chk("t37_set_wins", 32'(if0.runderflow), 32'd1);
        rinc = 1'b0;
        tick();
        chk("t37_clr", 32'(if0.runderflow), 32'd0);
        clr = 1'b0;

        // full FIFO and almost-empty threshold edges
        thresh = 6'd31;
        for (int k = 0; k < DEPTH; k++) push_word(8'(8'h40 + k));
        tick();
        chk("t36_s_level", 32'(if0.rlevel), 32'd32);
        chk("t36_f_level", 32'(if1.rlevel), 32'd32);
        chk("t36_ae31",    32'(if0.ralmostempty), 32'd0);
        thresh = 6'd32;
        tick();
        chk("t36_ae32",    32'(if0.ralmostempty), 32'd1);

        // randomized traffic including multi-word pointer jumps
        for (int c = 0; c < 400; c++) begin
            rinc = ($urandom_range(0, 99) < 55);
            clr  = ($urandom_range(0, 9) == 0);
            if (c % 50 == 0) thresh = 6'($urandom_range(0, 33));
            n = int'($urandom_range(0, 2));
            for (int k = 0; k < n; k++) if (room()) push_word(8'($urandom));
            tick();
        end
        rinc = 1'b0;
        clr  = 1'b0;
        tick();

        // pointer wrap: advance read pointer to 62, then jump write pointer to 1
        async_reset();
        thresh = 6'd1;
        tick();
        rinc = 1'b1;
        for (int c = 0; c < 300 && !(m0_rd == 62 && wr == 62); c++) begin
            if (wr != 62 && room()) push_word(8'(c));
            tick();
        end
        tick(); tick();
        chk("t35_preload_rptr", 32'(if0.rptr), bin2gray(32'd62));
        rinc = 1'b0;
        clr  = 1'b1;
        tick();
        clr  = 1'b0;
        push_word(8'hE0); push_word(8'hE1); push_word(8'hE2);
        tick();
        chk("t35_level", 32'(if0.rlevel), 32'd3);
        rinc = 1'b1;
        tick(); tick(); tick();
        rinc = 1'b0;
        chk("t35_raddr",  32'(if0.raddr),  32'd1);
        chk("t35_rptr",   32'(if0.rptr),   bin2gray(32'd1));
        chk("t35_rempty", 32'(if0.rempty), 32'd1);
        chk("t35_rdata",  32'(if0.rdata),  32'hE2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rptr_empty_prog.md
RPTR_EMPTY_PROG -- requirements
Module: rptr_empty_prog

Interface
REQ-001 Parameter ASIZE, default 5: address width; FIFO depth is 2**ASIZE.
REQ-002 Parameter DSIZE, default 8: data width.
REQ-003 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-004 rclk  in  1  read-domain clock; the only clock.
REQ-005 rrst_n  in  1  reset; asynchronous, active-low.
REQ-006 rinc  in  1  pop request.
REQ-007 rq2_wptr  in  ASIZE+1  write pointer, Gray-coded, already synchronised into rclk.
REQ-008 rmem_data  in  DSIZE  asynchronous-read memory output at raddr.
REQ-009 ae_thresh  in  ASIZE+1  runtime almost-empty threshold, quasi-static.
REQ-010 runderflow_clr  in  1  clear pulse for runderflow.
REQ-011 raddr  out  ASIZE  memory read address.
REQ-012 rptr  out  ASIZE+1  registered Gray read pointer, sent to the write domain.
REQ-013 rdata  out  DSIZE  registered read data.
REQ-014 rvalid  out  1  rdata valid qualifier.
REQ-015 rempty  out  1  registered empty flag.
REQ-016 ralmostempty  out  1  registered almost-empty flag.
REQ-017 rlevel  out  ASIZE+1  registered occupancy as seen by the reader.
REQ-018 runderflow  out  1  sticky underflow flag.

Function
REQ-019 Keep binary read pointer rbin[ASIZE:0]; raddr = rbin[ASIZE-1:0]; rptr = Gray(rbin), both registered.
REQ-020 Convert rq2_wptr to binary wbin combinationally; mem_level = (wbin - rbin) mod 2**(ASIZE+1); mem_empty = (mem_level == 0).
REQ-021 FWFT=0: a pop is accepted when rinc=1 and rempty=0.
  - rdata <= rmem_data and rbin <= rbin+1 on that edge.
  - rvalid = 1 for exactly the following cycle.
  - Otherwise rdata holds and rvalid = 0.
  - rempty = registered (next-cycle mem_level == 0).
REQ-022 FWFT=1: an internal head register holds one word.
  - Fetch when mem_empty=0 and (head empty, or head popped this cycle): rdata <= rmem_data, rbin increments.
  - rvalid = head valid; rempty = !rvalid.
  - A pop is accepted when rinc=1 and rvalid=1; it is combined with a fetch in the same cycle where possible.
REQ-023 First word after empty: rvalid rises 1 rclk after rq2_wptr changes (FWFT=1); rempty falls 1 rclk after (FWFT=0).
REQ-024 rlevel = next mem_level (FWFT=0), or next mem_level + next head valid (FWFT=1); registered.
  - rlevel never exceeds 2**ASIZE.
  - Pointer wrap at 2**(ASIZE+1) is handled by modular subtraction.
REQ-025 ralmostempty = registered (next rlevel <= ae_thresh).
  - ae_thresh = 0: ralmostempty equals rempty.
  - ae_thresh >= 2**ASIZE: ralmostempty is constantly 1.
REQ-026 rinc=1 while rempty=1 sets runderflow on the next edge; pointers and rdata are unchanged.
REQ-027 runderflow clears on runderflow_clr; a simultaneous set wins over the clear.
REQ-028 rq2_wptr moving by more than one position per cycle (synchroniser skew recovery) is tolerated; flags follow the new value.

Reset
REQ-029 Asynchronous assertion of rrst_n=0 forces, immediately:
  - rbin = 0, rptr = 0, rdata = 0, rlevel = 0, rvalid = 0, runderflow = 0;
  - rempty = 1, ralmostempty = 1.
REQ-030 Deassertion is synchronous to rclk. A reset mid-transfer discards the head word. No pop is accepted in the first cycle after deassertion.

Structure
REQ-031 Package fifo_pkg: bin2gray and gray2bin functions, and the FWFT mode constants.
REQ-032 One sub-module, gray2bin (parameter ASIZE+1), converts rq2_wptr; all other logic is in rptr_empty_prog.

Verification
REQ-033 Reset then rq2_wptr=Gray(3), ASIZE=5, FWFT=0, ae_thresh=1 -> one cycle later rempty=0, rlevel=3, ralmostempty=0; three pops -> rdata = words 0,1,2; after the 3rd pop rempty=1, rlevel=0.
REQ-034 FWFT=1, write 1 word -> rvalid=1 with rdata=word0 one cycle after the pointer update, with no rinc; rinc for one cycle -> rvalid=0 next cycle, rptr=Gray(1).
REQ-035 Wrap: preload rbin=62, wbin=1 (mod 64) -> rlevel=3; pop 3 -> rbin=1, rptr=Gray(1), rempty=1.
REQ-036 Full FIFO, wbin-rbin=32 -> rlevel=32, ralmostempty=0 with ae_thresh=31; ae_thresh=32 -> ralmostempty=1.
REQ-037 rinc while empty -> runderflow=1 next cycle, rptr unchanged; runderflow_clr and a new underflow in the same cycle -> runderflow stays 1; clr alone -> 0.
REQ-038 Assert rrst_n=0 mid-burst between clock edges -> all outputs take their reset values before the next rclk edge.
